main_memory_responder: RTL and testbench

// - Memory-side end of the cache_memory refill/write-back interface: serves block refills (read_en_mem)
//   and accepts dirty-victim write-backs (write_en_mem) with fixed, parameterised latency.
// - Sits below the n-way cache controller. data_out_mem drives cache data_in_mem; dirty_block_in is fed

---
 rtl/main_memory_responder_if.sv | 24 ++
 rtl/main_memory_responder.sv | 150 +++++++++++++++
 tb/tb_main_memory_responder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/main_memory_responder_if.sv
// Block-transfer handshake between the cache controller (master) and the
// main-memory responder (slave): level requests in, one-cycle ready pulse out.
interface main_memory_responder_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int BLOCK_SIZE = 128
);
   logic                  read_en_mem;
   logic                  write_en_mem;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [BLOCK_SIZE-1:0] dirty_block_in;
   logic [BLOCK_SIZE-1:0] data_out_mem;
   logic                  mem_ready;
   logic                  mem_busy;

   modport master (
      output read_en_mem, write_en_mem, mem_addr, dirty_block_in,
      input  data_out_mem, mem_ready, mem_busy
   );

   modport slave (
      input  read_en_mem, write_en_mem, mem_addr, dirty_block_in,
      output data_out_mem, mem_ready, mem_busy
   );
endinterface

// File: rtl/main_memory_responder.sv
// Fixed-latency main memory serving block refills and dirty-victim write-backs.
// Define MEM_STATS_EN to add saturating rd_count/wr_count completion counters.
module main_memory_responder #(
   parameter int WORD_SIZE       = 32,
   parameter int WORDS_PER_BLOCK = 4,
   parameter int ADDR_WIDTH      = 32,
   parameter int MEM_BLOCKS      = 1024,
   parameter int RD_LATENCY      = 4,
   parameter int WR_LATENCY      = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   main_memory_responder_if.slave    bus
`ifdef MEM_STATS_EN
   ,
   output logic [15:0]               rd_count,
   output logic [15:0]               wr_count
`endif
);

   localparam int BLOCK_SIZE   = WORD_SIZE * WORDS_PER_BLOCK;
   localparam int BA_W         = $clog2(MEM_BLOCKS);
   localparam int OFFSET_WIDTH = $clog2(WORDS_PER_BLOCK);
   localparam int MAX_LAT      = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
   localparam int CNT_W        = $clog2(MAX_LAT + 1);
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD_WAIT,
      S_WR_WAIT,
      S_RESP
   } state_t;

   state_t                  r_state;
   logic [CNT_W-1:0]        r_cnt;
   logic [BA_W-1:0]         r_addr;
   logic [BLOCK_SIZE-1:0]   r_wdata;
   logic [BLOCK_SIZE-1:0]   r_data_out;
   logic                    r_ready;
   logic                    r_busy;
   logic                    r_op_wr;
   logic [BLOCK_SIZE-1:0]   r_mem [MEM_BLOCKS];

   logic [BA_W-1:0]         w_blk_addr;
   logic                    w_wr_fire;
   logic                    w_unused_addr;

   // Bits above the block index alias (wrap) and word-offset bits are ignored.
   assign w_blk_addr    = bus.mem_addr[OFFSET_WIDTH +: BA_W];
   assign w_unused_addr = ^bus.mem_addr;
   assign w_wr_fire     = !rst && (r_state == S_WR_WAIT) && (r_cnt == '0);

   // NOTE: the backing array has no reset; only the commit condition guards it,
   // so a reset mid-write simply never reaches the write enable.
   always_ff @(posedge clk) begin
      if (w_wr_fire) begin
         r_mem[r_addr] <= r_wdata;
      end
   end

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_data_out <= '0;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_op_wr    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.write_en_mem) begin
                  // Write wins so the victim lands before the refill that follows.
                  r_state <= S_WR_WAIT;
                  r_cnt   <= WR_LOAD;
                  r_addr  <= w_blk_addr;
                  r_wdata <= bus.dirty_block_in;
                  r_busy  <= 1'b1;
                  r_op_wr <= 1'b1;
               end else if (bus.read_en_mem) begin
                  r_state <= S_RD_WAIT;
                  r_cnt   <= RD_LOAD;
                  r_addr  <= w_blk_addr;
                  r_busy  <= 1'b1;
                  r_op_wr <= 1'b0;
               end
            end
            S_RD_WAIT: begin
               if (r_cnt == '0) begin
                  r_state    <= S_RESP;
                  r_data_out <= r_mem[r_addr];
                  r_ready    <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_WR_WAIT: begin
               if (r_cnt == '0) begin
                  r_state <= S_RESP;
                  r_ready <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_out_mem = r_data_out;
   assign bus.mem_ready    = r_ready;
   assign bus.mem_busy     = r_busy;

`ifdef MEM_STATS_EN
   logic [15:0] r_rd_count;
   logic [15:0] r_wr_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_count <= '0;
         r_wr_count <= '0;
      end else if (r_state == S_RESP) begin
         if (r_op_wr) begin
            if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
         end else begin
            if (r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
         end
      end
   end

   assign rd_count = r_rd_count;
   assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: table of write/read transactions
// plus hand-written sequences for simultaneous requests, reset mid-op and stats.
module tb_main_memory_responder;

   localparam int RD_LAT   = 4;
   localparam int WR_LAT   = 4;
   localparam int MAX_WAIT = 40;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   main_memory_responder_if #(.ADDR_WIDTH(32), .BLOCK_SIZE(128)) bus ();

`ifdef MEM_STATS_EN
   logic [15:0] rd_count;
   logic [15:0] wr_count;
`endif

   main_memory_responder #(
      .WORD_SIZE(32), .WORDS_PER_BLOCK(4), .ADDR_WIDTH(32),
      .MEM_BLOCKS(1024), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef MEM_STATS_EN
      ,
      .rd_count(rd_count),
      .wr_count(wr_count)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   typedef struct {
      logic          is_wr;
      logic [31:0]   addr;
      logic [127:0]  wdata;
      logic [127:0]  exp_rdata;
   } vec_t;

   vec_t vecs[9];

   // Runs one transaction from IDLE; returns cycles from acceptance edge to ready.
   task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [127:0] wdata,
                          output int lat, output logic busy_ok);
      bit done = 0;
      @(negedge clk);
      bus.write_en_mem   = wr;
      bus.read_en_mem    = ~wr;
      bus.mem_addr       = addr;
      bus.dirty_block_in = wdata;
      lat     = 0;
      busy_ok = 1'b1;
      for (int i = 0; i < MAX_WAIT; i++) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
         if (!bus.mem_busy) busy_ok = 1'b0;
         if (bus.mem_ready) begin
            done = 1;
            break;
         end
      end
      lat = done ? lat - 1 : -1;
      bus.write_en_mem = 1'b0;
      bus.read_en_mem  = 1'b0;
   endtask

   initial begin
      int          lat;
      int          edges;
      logic        busy_ok;
      logic        changed;
      logic        saw_ready;
      logic [127:0] prev;

      vecs[0] = '{1'b1, 32'h0000_0400, 128'hCAFEBABE_FEEDFACE_DEADBEAF_87654321, 128'h0};
      vecs[1] = '{1'b0, 32'h0000_0400, 128'h0, 128'hCAFEBABE_FEEDFACE_DEADBEAF_87654321};
      vecs[2] = '{1'b1, 32'h0000_0800, 128'h44445555_66667777_88889999_AAAA0000, 128'h0};
      vecs[3] = '{1'b0, 32'h0000_0800, 128'h0, 128'h44445555_66667777_88889999_AAAA0000};
      vecs[4] = '{1'b1, 32'h0000_10C0, 128'h11112222_33334444_55556666_77778888, 128'h0};
      vecs[5] = '{1'b0, 32'h0000_00C0, 128'h0, 128'h11112222_33334444_55556666_77778888};
      vecs[6] = '{1'b0, 32'h0000_00C3, 128'h0, 128'h11112222_33334444_55556666_77778888};
      vecs[7] = '{1'b1, 32'h0000_00C0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'h0};
      vecs[8] = '{1'b0, 32'h0000_10C0, 128'h0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};

      bus.read_en_mem    = 1'b0;
      bus.write_en_mem   = 1'b0;
      bus.mem_addr       = '0;
      bus.dirty_block_in = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ready", 128'(bus.mem_ready), 128'd0);
      check("reset_busy", 128'(bus.mem_busy), 128'd0);
      check("reset_data", bus.data_out_mem, 128'd0);
      rst = 1'b0;

      // Table-driven write/read transactions, including address wrap and offset bits
      prev = '0;
      for (int v = 0; v < 9; v++) begin
         run_txn(vecs[v].is_wr, vecs[v].addr, vecs[v].wdata, lat, busy_ok);
         check($sformatf("v%0d_latency", v), 128'(lat), 128'(vecs[v].is_wr ? WR_LAT : RD_LAT));
         check($sformatf("v%0d_busy", v), 128'(busy_ok), 128'd1);
         if (vecs[v].is_wr) begin
            check($sformatf("v%0d_data_hold", v), bus.data_out_mem, prev);
         end else begin
            check($sformatf("v%0d_rdata", v), bus.data_out_mem, vecs[v].exp_rdata);
            prev = vecs[v].exp_rdata;
         end
         @(posedge clk);
         @(negedge clk);
         check($sformatf("v%0d_ready_pulse", v), 128'(bus.mem_ready), 128'd0);
         check($sformatf("v%0d_busy_clear", v), 128'(bus.mem_busy), 128'd0);
      end

      // Simultaneous read and write: write first, read accepted afterwards in IDLE
      @(negedge clk);
      bus.write_en_mem   = 1'b1;
      bus.read_en_mem    = 1'b1;
      bus.mem_addr       = 32'h0000_0240;
      bus.dirty_block_in = 128'hABCD_0001_ABCD_0002_ABCD_0003_ABCD_0004;
      edges     = 0;
      changed   = 1'b0;
      saw_ready = 1'b0;
      for (int i = 0; i < MAX_WAIT; i++) begin
         @(posedge clk);
         @(negedge clk);
         edges++;
         if (bus.data_out_mem !== prev) changed = 1'b1;
         if (bus.mem_ready) begin
            saw_ready = 1'b1;
            break;
         end
      end
      check("simul_wr_seen", 128'(saw_ready), 128'd1);
      check("simul_wr_latency", 128'(edges - 1), 128'(WR_LAT));
      bus.write_en_mem = 1'b0;
      edges     = 0;
      saw_ready = 1'b0;
      for (int i = 0; i < MAX_WAIT; i++) begin
         @(posedge clk);
         @(negedge clk);
         edges++;
         if (bus.mem_ready) begin
            saw_ready = 1'b1;
            break;
         end
         if (bus.data_out_mem !== prev) changed = 1'b1;
      end
      bus.read_en_mem = 1'b0;
      check("simul_rd_seen", 128'(saw_ready), 128'd1);
      check("simul_rd_latency", 128'(edges), 128'(RD_LAT + 2));
      check("simul_data_unchanged", 128'(changed), 128'd0);
      check("simul_rdata", bus.data_out_mem, 128'hABCD_0001_ABCD_0002_ABCD_0003_ABCD_0004);

      // Reset two cycles into WR_WAIT: write discarded, no ready pulse
      @(negedge clk);
      bus.write_en_mem   = 1'b1;
      bus.mem_addr       = 32'h0000_0800;
      bus.dirty_block_in = 128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rstmid_busy_before", 128'(bus.mem_busy), 128'd1);
      rst              = 1'b1;
      bus.write_en_mem = 1'b0;
      saw_ready        = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rstmid_ready", 128'(bus.mem_ready), 128'd0);
      check("rstmid_busy", 128'(bus.mem_busy), 128'd0);
      check("rstmid_data", bus.data_out_mem, 128'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.mem_ready) saw_ready = 1'b1;
      end
      check("rstmid_no_pulse", 128'(saw_ready), 128'd0);
      run_txn(1'b0, 32'h0000_0800, 128'h0, lat, busy_ok);
      check("rstmid_old_contents", bus.data_out_mem, 128'h44445555_66667777_88889999_AAAA0000);

`ifdef MEM_STATS_EN
      check("stats_rd_count", 128'(rd_count), 128'd1);
      @(negedge clk);
      force dut.r_wr_count = 16'hFFFE;
      #1;
      release dut.r_wr_count;
      for (int k = 0; k < 3; k++) begin
         run_txn(1'b1, 32'h0000_0300, 128'(k), lat, busy_ok);
      end
      repeat (2) @(negedge clk);
      check("stats_wr_saturate", 128'(wr_count), 128'hFFFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
